step_ctrl: RTL and testbench

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 103 ++++++++++
 tb/tb_step_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// CPU clock-enable controller: HALT / RUN / SLOW (programmable divide) / STEP
// (debounced-by-sync single step), plus a running count of issued enables.
module step_ctrl #(
  parameter logic [27:0] DIVISOR = 28'd20000000
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic        div_load,
  input  logic [27:0] div_value,
  input  logic        step_btn,
  output logic        cpu_ce,
  output logic        slow_clk,
  output logic [1:0]  state,
  output logic [31:0] ce_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_SLOW = 2'b10,
    ST_STEP = 2'b11
  } state_t;

  // A ratio below 2 cannot form a period, so it collapses to 1 (enable every cycle).
  function automatic logic [27:0] clamp_div(input logic [27:0] v);
    return (v < 28'd2) ? 28'd1 : v;
  endfunction

  state_t      state_q;
  logic [27:0] counter;
  logic [27:0] div_act;
  logic [27:0] div_pend;
  logic        pend_vld;
  logic        step_p0, step_p1, step_p2;

  logic        step_edge;
  logic        wrap;
  logic [27:0] cnt_nxt;
  logic [27:0] div_nxt;

  assign state = state_q;

  always_comb begin
    step_edge = step_p1 & ~step_p2;
    wrap      = (state_q == ST_SLOW) && (counter >= div_act - 28'd1);

    // A load landing on a wrap takes effect for the period that starts there.
    div_nxt = div_act;
    if (div_load && ((state_q != ST_SLOW) || wrap))
      div_nxt = clamp_div(div_value);
    else if (wrap && pend_vld)
      div_nxt = div_pend;

    cnt_nxt = '0;
    if ((mode == ST_SLOW) && (state_q == ST_SLOW) && !wrap)
      cnt_nxt = counter + 28'd1;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HALT;
      counter  <= '0;
      div_act  <= clamp_div(DIVISOR);
      div_pend <= '0;
      pend_vld <= 1'b0;
      step_p0  <= 1'b0;
      step_p1  <= 1'b0;
      step_p2  <= 1'b0;
      cpu_ce   <= 1'b0;
      slow_clk <= 1'b0;
      ce_count <= '0;
    end else begin
      // stage p0/p1: two-flop synchronizer, p2: previous level for edge detect
      step_p0 <= step_btn;
      step_p1 <= step_p0;
      step_p2 <= step_p1;

      state_q <= state_t'(mode);
      counter <= cnt_nxt;
      div_act <= div_nxt;

      if (div_load && (state_q == ST_SLOW) && !wrap) begin
        div_pend <= clamp_div(div_value);
        pend_vld <= 1'b1;
      end else if (div_load || wrap) begin
        pend_vld <= 1'b0;
      end

      unique case (state_q)
        ST_RUN:  cpu_ce <= 1'b1;
        ST_SLOW: cpu_ce <= wrap;
        ST_STEP: cpu_ce <= step_edge;
        default: cpu_ce <= 1'b0;
      endcase

      // Aligned with the counter value the next cycle will hold.
      slow_clk <= (mode == ST_SLOW) && (cnt_nxt < (div_nxt >> 1));
      ce_count <= ce_count + {31'd0, cpu_ce};
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl built with DIVISOR=4: reset, RUN, SLOW with
// deferred and same-cycle divisor loads, STEP edge handling, mid-period reset.
module tb_step_ctrl;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b1;
  logic [1:0]  mode     = 2'b00;
  logic        div_load = 1'b0;
  logic [27:0] div_value = '0;
  logic        step_btn = 1'b0;
  logic        cpu_ce;
  logic        slow_clk;
  logic [1:0]  state;
  logic [31:0] ce_count;

  step_ctrl #(.DIVISOR(28'd4)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .mode     (mode),
    .div_load (div_load),
    .div_value(div_value),
    .step_btn (step_btn),
    .cpu_ce   (cpu_ce),
    .slow_clk (slow_clk),
    .state    (state),
    .ce_count (ce_count)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [1:0]  mode;
    logic        ld;
    logic [27:0] val;
    logic        btn;
    logic [1:0]  st;
    logic        ce;
    logic        sl;
    logic [31:0] cec;
  } vec_t;

  vec_t tbl[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(int m, int ld, int val, int btn, int st, int ce, int sl, int cec);
    vec_t v;
    v.mode = 2'(m);  v.ld = 1'(ld); v.val = 28'(val); v.btn = 1'(btn);
    v.st   = 2'(st); v.ce = 1'(ce); v.sl  = 1'(sl);   v.cec = 32'(cec);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    int n, first, last, found, at;
    logic [7:0] sl_pat;

    // mode, ld, val, btn -> state, cpu_ce, slow_clk, ce_count (after the edge)
    tbl.push_back(mk(2,0,0,0, 2,0,1,10));  // enter SLOW, counter 0
    tbl.push_back(mk(2,0,0,0, 2,0,1,10));
    tbl.push_back(mk(2,0,0,0, 2,0,0,10));
    tbl.push_back(mk(2,0,0,0, 2,0,0,10));
    tbl.push_back(mk(2,0,0,0, 2,1,1,10));  // wrap
    tbl.push_back(mk(2,0,0,0, 2,0,1,11));
    tbl.push_back(mk(2,1,6,0, 2,0,0,11));  // load 6 at counter=1 -> pending
    tbl.push_back(mk(2,0,0,0, 2,0,0,11));
    tbl.push_back(mk(2,0,0,0, 2,1,1,11));  // wrap, period becomes 6
    tbl.push_back(mk(2,0,0,0, 2,0,1,12));
    tbl.push_back(mk(2,0,0,0, 2,0,1,12));
    tbl.push_back(mk(2,0,0,0, 2,0,0,12));
    tbl.push_back(mk(2,0,0,0, 2,0,0,12));
    tbl.push_back(mk(2,0,0,0, 2,0,0,12));
    tbl.push_back(mk(2,0,0,0, 2,1,1,12));
    tbl.push_back(mk(2,0,0,0, 2,0,1,13));
    tbl.push_back(mk(0,0,0,0, 0,0,0,13));  // leave mid-period: no pulse
    tbl.push_back(mk(0,0,0,0, 0,0,0,13));
    tbl.push_back(mk(0,1,0,0, 0,0,0,13));  // load 0 in HALT -> ratio 1
    tbl.push_back(mk(2,0,0,0, 2,0,0,13));
    tbl.push_back(mk(2,0,0,0, 2,1,0,13));
    tbl.push_back(mk(2,0,0,0, 2,1,0,14));
    tbl.push_back(mk(2,0,0,0, 2,1,0,15));
    tbl.push_back(mk(2,1,4,0, 2,1,1,16));  // load on a wrap applies at once
    tbl.push_back(mk(2,0,0,0, 2,0,1,17));
    tbl.push_back(mk(2,0,0,0, 2,0,0,17));
    tbl.push_back(mk(2,0,0,0, 2,0,0,17));
    tbl.push_back(mk(2,0,0,0, 2,1,1,17));
    tbl.push_back(mk(0,0,0,0, 0,0,0,18));
    tbl.push_back(mk(0,0,0,1, 0,0,0,18));  // step edge while HALT is dropped
    tbl.push_back(mk(0,0,0,1, 0,0,0,18));
    tbl.push_back(mk(0,0,0,1, 0,0,0,18));
    tbl.push_back(mk(0,0,0,1, 0,0,0,18));
    tbl.push_back(mk(3,0,0,1, 3,0,0,18));
    tbl.push_back(mk(3,0,0,1, 3,0,0,18));
    tbl.push_back(mk(3,0,0,0, 3,0,0,18));
    tbl.push_back(mk(3,0,0,0, 3,0,0,18));
    tbl.push_back(mk(3,0,0,0, 3,0,0,18));

    // Reset state
    #1 reset_n = 1'b0;
    tick; tick;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_slow", 32'(slow_clk), 32'd0);
    check("rst_count", ce_count, 32'd0);
    reset_n = 1'b1;

    // RUN for 10 edges: ten consecutive enables
    n = 0; first = 0; last = 0;
    for (int k = 1; k <= 14; k++) begin
      mode = (k <= 10) ? 2'b01 : 2'b00;
      tick;
      if (cpu_ce) begin
        n++;
        if (first == 0) first = k;
        last = k;
      end
    end
    check("run_pulses", 32'(n), 32'd10);
    check("run_first", 32'(first), 32'd2);
    check("run_last", 32'(last), 32'd11);
    check("run_count", ce_count, 32'd10);

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      mode = tbl[i].mode; div_load = tbl[i].ld; div_value = tbl[i].val; step_btn = tbl[i].btn;
      tick;
      check($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("v%0d_ce", i), 32'(cpu_ce), 32'(tbl[i].ce));
      check($sformatf("v%0d_slow", i), 32'(slow_clk), 32'(tbl[i].sl));
      check($sformatf("v%0d_count", i), ce_count, tbl[i].cec);
    end
    div_load = 1'b0; step_btn = 1'b0;

    // Reset mid-SLOW at ce_count=7 with a non-default ratio
    reset_n = 1'b0; mode = 2'b00;
    tick; tick;
    reset_n = 1'b1;
    div_load = 1'b1; div_value = 28'd2;
    tick;
    div_load = 1'b0; mode = 2'b10;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (ce_count == 32'd7 && slow_clk && cpu_ce) begin
        found = 1;
        break;
      end
    end
    check("slow_reach7", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_ce", 32'(cpu_ce), 32'd0);
    check("async_slow", 32'(slow_clk), 32'd0);
    check("async_count", ce_count, 32'd0);
    tick; tick;
    reset_n = 1'b1;
    n = 0; first = 0; sl_pat = '0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (k <= 8) sl_pat[k-1] = slow_clk;
      if (cpu_ce) begin
        n++;
        if (first == 0) first = k;
      end
    end
    check("div_rst_pulses", 32'(n), 32'd2);
    check("div_rst_first", 32'(first), 32'd5);
    check("div_rst_slowpat", 32'(sl_pat), 32'h33);

    // STEP: held button gives one pulse three edges after the rise
    reset_n = 1'b0; mode = 2'b11;
    tick;
    reset_n = 1'b1;
    tick; tick;
    step_btn = 1'b1;
    n = 0; at = 0;
    for (int k = 1; k <= 50; k++) begin
      tick;
      if (cpu_ce) begin
        n++;
        at = k;
      end
    end
    check("step_pulses", 32'(n), 32'd1);
    check("step_latency", 32'(at), 32'd3);
    check("step_count1", ce_count, 32'd1);
    step_btn = 1'b0;
    repeat (5) tick;
    step_btn = 1'b1;
    repeat (6) tick;
    step_btn = 1'b0;
    repeat (3) tick;
    check("step_count2", ce_count, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
